// File: rtl/word_serializer_pkg.sv
// Shared types and sizing helpers for the word serializer.
// The default geometry matches the upstream rotator (32-bit bus of 4-bit words).
package word_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned BUS_SIZE_DEF  = 32;
    localparam int unsigned WORD_SIZE_DEF = 4;
    localparam int unsigned ERR_CNT_W_DEF = 8;
    localparam int unsigned WORD_NUM_DEF  = BUS_SIZE_DEF / WORD_SIZE_DEF;

    // Index width for n words; a single-word bus still needs one index bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IDX_W_DEF = idx_width(WORD_NUM_DEF);

endpackage

// File: rtl/word_serializer_msb_index_encoder.sv
// Highest-set-bit encoder for the remaining word mask, plus an
// "exactly one bit left" flag that marks the final word of a burst.
module msb_index_encoder
    import word_serializer_pkg::*;
#(
    parameter int unsigned WORD_NUM = WORD_NUM_DEF,
    parameter int unsigned IDX_W    = IDX_W_DEF
) (
    input  logic [WORD_NUM-1:0] mask_i,
    output logic [IDX_W-1:0]    idx_o,
    output logic                one_hot_left_o
);

    // Ascending scan so the highest set bit wins.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < int'(WORD_NUM); i++) begin
            if (mask_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign one_hot_left_o = (mask_i != '0) &&
                            ((mask_i & (mask_i - WORD_NUM'(1))) == '0);

endmodule

// File: rtl/word_serializer.sv
// Serializes the enabled words of a rotator bus, highest index first, and
// counts error buses. Accepts a new bus on the edge of the previous last word.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int unsigned BUS_SIZE  = BUS_SIZE_DEF,
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
    parameter int unsigned ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [BUS_SIZE-1:0]              data_in,
    input  logic [BUS_SIZE/WORD_SIZE-1:0]    control_in,
    input  logic                             error_in,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [WORD_SIZE-1:0]             word_out,
    output logic                             word_valid,
    input  logic                             word_ready,
    output logic                             word_last,
    output logic                             err_pulse,
    output logic [ERR_CNT_W-1:0]             err_count
);

    localparam int unsigned WORD_NUM = BUS_SIZE / WORD_SIZE;
    localparam int unsigned IDX_W    = idx_width(WORD_NUM);

    state_e                 state_q, state_d;
    logic [WORD_NUM-1:0]    mask_q, mask_d;
    logic [BUS_SIZE-1:0]    data_q, data_d;
    logic                   err_pulse_q, err_pulse_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

    logic [IDX_W-1:0]       hi_idx;
    logic                   one_left;
    logic [WORD_SIZE-1:0]   words [WORD_NUM];
    logic                   accept;
    logic                   word_hs;
    logic                   last_hs;

    msb_index_encoder #(
        .WORD_NUM (WORD_NUM),
        .IDX_W    (IDX_W)
    ) u_msb_index_encoder (
        .mask_i         (mask_q),
        .idx_o          (hi_idx),
        .one_hot_left_o (one_left)
    );

    for (genvar g = 0; g < WORD_NUM; g++) begin : g_words
        assign words[g] = data_q[g*WORD_SIZE +: WORD_SIZE];
    end

    // Outputs read zero for the whole reset cycle, so an aborted burst never shows a last word.
    assign word_valid = !reset && (state_q == SHIFT);
    assign word_last  = word_valid && one_left;
    assign word_out   = word_valid ? words[hi_idx] : '0;
    assign err_pulse  = !reset && err_pulse_q;
    assign err_count  = reset ? '0 : err_count_q;

    assign word_hs  = word_valid && word_ready;
    assign last_hs  = word_hs && one_left;
    assign in_ready = !reset && ((state_q == IDLE) || last_hs);
    assign accept   = in_valid && in_ready;

    // Next state: retire the current word first, then let a new bus override.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        data_d      = data_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;

        if (word_hs) begin
            mask_d = mask_q & ~(WORD_NUM'(1) << hi_idx);
            if (one_left) begin
                state_d = IDLE;
            end
        end

        if (accept) begin
            if (error_in) begin
                err_pulse_d = 1'b1;
                state_d     = IDLE;
                if (err_count_q != {ERR_CNT_W{1'b1}}) begin
                    err_count_d = err_count_q + ERR_CNT_W'(1);
                end
            end else if (control_in != '0) begin
                data_d  = data_in;
                mask_d  = control_in;
                state_d = SHIFT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            data_q      <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Randomized self-checking bench for word_serializer against a queue-based
// model: each accepted bus expands to its enabled words, top index first.
module tb_word_serializer;

    localparam int WS = 4;
    localparam int WN = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic [7:0]  control_in;
    logic        error_in;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  word_out;
    logic        word_valid;
    logic        word_ready;
    logic        word_last;
    logic        err_pulse;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    word_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .control_in (control_in),
        .error_in   (error_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_last  (word_last),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  m;
        logic        e;
    } bus_t;

    bus_t        pend_q [$];
    logic [4:0]  exp_q  [$];
    logic [4:0]  obs_q  [$];
    int          acc_cyc[$];
    int          wcyc   [$];

    int vectors = 0;
    int miscompares = 0;
    int err_pulses;
    int exp_err_acc;
    int valid_cycles;
    int model_err_cnt = 0;

    function automatic void push_bus(input logic [31:0] d, input logic [7:0] m, input logic e);
        bus_t b;
        b.d = d;
        b.m = m;
        b.e = e;
        pend_q.push_back(b);
    endfunction

    // Reference: an error bus only bumps the saturating count; otherwise every
    // enabled word is emitted from index 7 down, last flag on the lowest one.
    function automatic void model_accept(input bus_t b);
        if (b.e) begin
            exp_err_acc++;
            if (model_err_cnt < 255) model_err_cnt++;
        end else begin
            for (int i = WN - 1; i >= 0; i--) begin
                if (b.m[i]) begin
                    exp_q.push_back({((b.m & ((8'd1 << i) - 8'd1)) == 8'd0), b.d[i*WS +: WS]});
                end
            end
        end
    endfunction

    // Feeds pend_q upstream, records downstream handshakes, checks protocol rules inline.
    task automatic run_stream(input string name, input int ready_pct, input int stall_start,
                              input int stall_len, input int max_cycles);
        int         cyc;
        int         idle;
        bit         done;
        bit         prev_held;
        logic [5:0] prev_out;
        exp_q.delete();
        obs_q.delete();
        acc_cyc.delete();
        wcyc.delete();
        err_pulses = 0;
        exp_err_acc = 0;
        valid_cycles = 0;
        cyc = 0;
        idle = 0;
        done = 1'b0;
        prev_held = 1'b0;
        prev_out = '0;
        while (!done) begin
            @(posedge clk);
            #1;
            if (pend_q.size() > 0) begin
                in_valid   = 1'b1;
                data_in    = pend_q[0].d;
                control_in = pend_q[0].m;
                error_in   = pend_q[0].e;
            end else begin
                in_valid   = 1'b0;
                data_in    = $urandom;
                control_in = 8'($urandom);
                error_in   = 1'($urandom);
            end
            word_ready = (int'($urandom_range(99)) < ready_pct) &&
                         !(cyc >= stall_start && cyc < stall_start + stall_len);
            @(negedge clk);
            if (prev_held) begin
                vectors++;
                if ({word_valid, word_last, word_out} !== prev_out) begin
                    miscompares++;
                    $display("FAIL %s hold@%0d: got %h required %h", name, cyc,
                             {word_valid, word_last, word_out}, prev_out);
                end
            end
            vectors++;
            if (in_ready !== (!word_valid || (word_ready && word_last))) begin
                miscompares++;
                $display("FAIL %s in_ready@%0d: got %b valid=%b ready=%b last=%b", name, cyc,
                         in_ready, word_valid, word_ready, word_last);
            end
            if (err_pulse) err_pulses++;
            if (word_valid) valid_cycles++;
            prev_held = word_valid && !word_ready;
            prev_out  = {word_valid, word_last, word_out};
            if (word_valid && word_ready) begin
                obs_q.push_back({word_last, word_out});
                wcyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                model_accept(pend_q.pop_front());
                acc_cyc.push_back(cyc);
            end
            cyc++;
            idle = (pend_q.size() == 0 && !word_valid) ? idle + 1 : 0;
            if (idle >= 2) done = 1'b1;
            if (!done && cyc >= max_cycles) begin
                vectors++;
                miscompares++;
                $display("FAIL %s timeout: ran %0d cycles, required completion", name, cyc);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s word count: got %0d required %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s word[%0d] {last,word}: got %h required %h", name, i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (err_pulses != exp_err_acc) begin
            miscompares++;
            $display("FAIL %s err_pulse cycles: got %0d required %0d", name, err_pulses, exp_err_acc);
        end
        vectors++;
        if (err_count !== 8'(model_err_cnt)) begin
            miscompares++;
            $display("FAIL %s err_count: got %0d required %0d", name, err_count, model_err_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if ({in_ready, word_valid, word_last, err_pulse, word_out, err_count} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset outputs: got rdy=%b v=%b l=%b p=%b w=%h c=%h required all 0",
                     in_ready, word_valid, word_last, err_pulse, word_out, err_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        word_ready = 1'b1;
        model_err_cnt = 0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset release: got in_ready=%b word_valid=%b required 1/0", in_ready, word_valid);
        end
    endtask

    task automatic test_full_mask();
        bit ok;
        push_bus(32'hF1234560, 8'hFF, 1'b0);
        run_stream("full_mask", 100, 0, 0, 50);
        ok = (wcyc.size() == 8) && (acc_cyc.size() == 1);
        for (int i = 0; ok && i < 8; i++) ok = (wcyc[i] == acc_cyc[0] + 1 + i);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL full_mask timing: got %0d words, first at %0d, required 8 consecutive from accept+1",
                     wcyc.size(), (wcyc.size() > 0) ? wcyc[0] : -1);
        end
    endtask

    task automatic test_two_words();
        push_bus(32'hF1234569, 8'h81, 1'b0);
        run_stream("two_words", 100, 0, 0, 50);
        vectors++;
        if (wcyc.size() != 2 || wcyc[1] != wcyc[0] + 1) begin
            miscompares++;
            $display("FAIL two_words spacing: got %0d words, required 2 adjacent", wcyc.size());
        end
    endtask

    task automatic test_backpressure();
        push_bus(32'hF1234560, 8'hFF, 1'b0);
        run_stream("backpressure", 100, 2, 3, 60);
        vectors++;
        if (valid_cycles != 11 || wcyc.size() != 8 || wcyc[7] != 11) begin
            miscompares++;
            $display("FAIL backpressure span: got %0d valid cycles, last word at %0d, required 11/11",
                     valid_cycles, (wcyc.size() > 0) ? wcyc[wcyc.size()-1] : -1);
        end
    endtask

    task automatic test_back_to_back();
        push_bus(32'hF0000001, 8'h81, 1'b0);
        push_bus(32'hFABCDEF2, 8'hC0, 1'b0);
        run_stream("back_to_back", 100, 0, 0, 50);
        vectors++;
        if (acc_cyc.size() != 2 || acc_cyc[0] != 0 || acc_cyc[1] != 2 || wcyc.size() != 4 ||
            wcyc[0] != 1 || wcyc[3] != 4) begin
            miscompares++;
            $display("FAIL back_to_back timing: got %0d accepts (2nd at %0d), %0d words, required accepts 0,2 words 1..4",
                     acc_cyc.size(), (acc_cyc.size() > 1) ? acc_cyc[1] : -1, wcyc.size());
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            push_bus($urandom, ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom), ($urandom_range(4) == 0));
        end
        run_stream("random", 70, 0, 0, 1500);
    endtask

    task automatic test_mid_reset();
        int  n;
        int  k;
        bit  saw_last;
        @(posedge clk);
        #1;
        in_valid   = 1'b1;
        data_in    = 32'hF1234560;
        control_in = 8'hFF;
        error_in   = 1'b0;
        word_ready = 1'b1;
        n = 0;
        k = 0;
        saw_last = 1'b0;
        while (n < 3 && k < 20) begin
            @(negedge clk);
            if (word_valid && word_ready) begin
                n++;
                if (word_last) saw_last = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            k++;
        end
        vectors++;
        if (n != 3 || saw_last) begin
            miscompares++;
            $display("FAIL mid_reset prefix: got %0d words (last seen=%b), required 3 without last", n, saw_last);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (word_valid !== 1'b0 || word_last !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset during: got v=%b l=%b cnt=%0d rdy=%b required 0/0/0/0",
                     word_valid, word_last, err_count, in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_err_cnt = 0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset release: got in_ready=%b word_valid=%b required 1/0", in_ready, word_valid);
        end
        push_bus(32'h9876543A, 8'hA5, 1'b0);
        run_stream("after_reset", 100, 0, 0, 50);
    endtask

    task automatic test_errors();
        for (int r = 0; r < 3; r++) begin
            push_bus(32'hF1234560, 8'hFF, 1'b1);
            run_stream("error_single", 100, 0, 0, 20);
            vectors++;
            if (valid_cycles != 0) begin
                miscompares++;
                $display("FAIL error_single word_valid cycles: got %0d required 0", valid_cycles);
            end
        end
        vectors++;
        if (err_count !== 8'd3) begin
            miscompares++;
            $display("FAIL error_count3: got %0d required 3", err_count);
        end
        for (int r = 0; r < 300; r++) push_bus($urandom, 8'($urandom), 1'b1);
        run_stream("error_saturate", 100, 0, 0, 400);
        vectors++;
        if (err_count !== 8'd255) begin
            miscompares++;
            $display("FAIL error_saturate: got %0d required 255", err_count);
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        data_in    = '0;
        control_in = '0;
        error_in   = 1'b0;
        word_ready = 1'b0;
        test_reset();
        test_full_mask();
        test_two_words();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_errors();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
